// File: rtl/mod_mul_word_serial.sv
// Word-serial unsigned multiplier: P = A*B using one DATA_SIZE x W_SIZE multiply per cycle.
// Optional MUL_ZERO_SKIP_EN finishes early once the remaining digits of B are all zero.
module mod_mul_word_serial #(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned W_SIZE    = 8,
  parameter int unsigned TAG_W     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_SIZE-1:0]     A,
  input  logic [DATA_SIZE-1:0]     B,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*DATA_SIZE-1:0]   P,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int unsigned K  = DATA_SIZE / W_SIZE;
  localparam int unsigned KW = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned PW = 2 * DATA_SIZE;

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e                      r_state;
  logic                        r_in_ready;
  logic                        r_out_valid;
  logic [PW-1:0]               r_p;
  logic [TAG_W-1:0]            r_out_tag;
  logic [TAG_W-1:0]            r_tag;
  logic [DATA_SIZE-1:0]        r_a;
  logic [DATA_SIZE-1:0]        r_b;
  logic [PW-1:0]               r_acc;
  logic [KW-1:0]               r_k;

  logic [W_SIZE-1:0]           w_digit;
  logic [DATA_SIZE+W_SIZE-1:0] w_pp;
  logic [PW-1:0]               w_pp_shift;
  logic [PW-1:0]               w_acc_next;
  logic                        w_last;

  // r_b is shifted right each cycle, so the current digit is always the low W_SIZE bits
  assign w_digit    = r_b[W_SIZE-1:0];
  assign w_pp       = {{W_SIZE{1'b0}}, r_a} * {{DATA_SIZE{1'b0}}, w_digit};
  assign w_pp_shift = PW'(w_pp) << (r_k * W_SIZE);
  assign w_acc_next = r_acc + w_pp_shift;

`ifdef MUL_ZERO_SKIP_EN
  assign w_last = (r_k == KW'(K - 1)) || ((r_b >> W_SIZE) == '0);
`else
  assign w_last = (r_k == KW'(K - 1));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_p         <= '0;
      r_out_tag   <= '0;
      r_tag       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_k         <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_a        <= A;
            r_b        <= B;
            r_tag      <= in_tag;
            r_acc      <= '0;
            r_k        <= '0;
            r_in_ready <= 1'b0;
            r_state    <= StMul;
          end
        end
        StMul: begin
          r_acc <= w_acc_next;
          r_b   <= r_b >> W_SIZE;
          if (w_last) begin
            // Counter parks at 0 so it never steps past K-1
            r_k         <= '0;
            r_p         <= w_acc_next;
            r_out_tag   <= r_tag;
            r_out_valid <= 1'b1;
            r_state     <= StDone;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign P         = r_p;
  assign out_tag   = r_out_tag;

endmodule
